// File: rtl/spi_master_ctrl.sv
// SPI master engine: runs one chip-select-framed transfer per accepted `work` request.
// Outgoing words are popped from a TX FIFO (zero fill when it runs dry). In read mode,
// each received word is pushed to an RX FIFO. Mode 0 timing, MSB first.
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   len, op, work       transfer length in bits, 0=read/1=write, start request
//   busy                high from the accepted request until the end of the cs_n hold
//   tx_rdata/tx_rd/tx_empty   TX FIFO read side (data valid the cycle after tx_rd)
//   rx_wdata/rx_wr/rx_full    RX FIFO write side
//   sclk, cs_n, mosi, miso    SPI pins
module spi_master_ctrl #(
    parameter int unsigned DATA    = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     len,
    input  logic            op,
    input  logic            work,
    output logic            busy,
    input  logic [DATA-1:0] tx_rdata,
    output logic            tx_rd,
    input  logic            tx_empty,
    output logic [DATA-1:0] rx_wdata,
    output logic            rx_wr,
    input  logic            rx_full,
    output logic            sclk,
    output logic            cs_n,
    output logic            mosi,
    input  logic            miso
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GW = $clog2(DATA + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFetch,
        StShift,
        StStore,
        StFinish
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     bits_left_q, bits_left_d;
    logic            op_q, op_d;
    logic [DATA-1:0] tx_sh_q, tx_sh_d;
    logic [DATA-1:0] rx_sh_q, rx_sh_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]   grp_q, grp_d;
    logic            sclk_q, sclk_d;
    logic [GW-1:0]   bit_next;
    logic            cnt_last;

    assign bit_next = bit_cnt_q + GW'(1);
    assign cnt_last = (cnt_q == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            bits_left_q <= '0;
            op_q        <= 1'b0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            grp_q       <= '0;
            sclk_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bits_left_q <= bits_left_d;
            op_q        <= op_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            grp_q       <= grp_d;
            sclk_q      <= sclk_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bits_left_d = bits_left_q;
        op_d        = op_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        grp_d       = grp_q;
        sclk_d      = sclk_q;
        tx_rd       = 1'b0;
        rx_wr       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (work && (len != 16'd0)) begin
                    bits_left_d = len;
                    op_d        = op;
                    state_d     = StLoad;
                end
            end
            StLoad: begin
                // Start of a shift group: size is the smaller of a full word and what is left.
                rx_sh_d   = '0;
                bit_cnt_d = '0;
                cnt_d     = '0;
                grp_d     = (bits_left_q >= 16'(DATA)) ? GW'(DATA) : GW'(bits_left_q);
                if (!tx_empty) begin
                    tx_rd   = 1'b1;
                    state_d = StFetch;
                end else begin
                    tx_sh_d = '0;
                    state_d = StShift;
                end
            end
            StFetch: begin
                tx_sh_d = tx_rdata;
                state_d = StShift;
            end
            StShift: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        rx_sh_d = {rx_sh_q[DATA-2:0], miso};
                    end else begin
                        sclk_d    = 1'b0;
                        tx_sh_d   = tx_sh_q << 1;
                        bit_cnt_d = bit_next;
                        if (bit_next == grp_q) begin
                            bits_left_d = bits_left_q - 16'(grp_q);
                            state_d     = StStore;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StStore: begin
                // Read mode waits here (cs_n low, sclk low) while the RX FIFO is full.
                if (op_q || !rx_full) begin
                    rx_wr   = !op_q;
                    cnt_d   = '0;
                    state_d = (bits_left_q != 16'd0) ? StLoad : StFinish;
                end
            end
            StFinish: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign cs_n     = (state_q == StIdle) || (state_q == StFinish);
    assign sclk     = sclk_q;
    assign mosi     = (state_q == StShift) && tx_sh_q[DATA-1];
    assign rx_wdata = rx_sh_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: FIFO and SPI-slave models, directed scenarios and
// randomized transfers, expected values derived from transfer-level rules.
module tb_spi_master_ctrl;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] len = '0;
    logic        op = 1'b0;
    logic        work = 1'b0;
    logic        busy;
    logic [7:0]  tx_rdata = '0;
    logic        tx_rd;
    logic        tx_empty;
    logic [7:0]  rx_wdata;
    logic        rx_wr;
    logic        rx_full = 1'b0;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;

    spi_master_ctrl #(
        .DATA    (8),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .len      (len),
        .op       (op),
        .work     (work),
        .busy     (busy),
        .tx_rdata (tx_rdata),
        .tx_rd    (tx_rd),
        .tx_empty (tx_empty),
        .rx_wdata (rx_wdata),
        .rx_wr    (rx_wr),
        .rx_full  (rx_full),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso)
    );

    always #5 clk = ~clk;

    // TX FIFO model: absolute read pointer, bench appends data by raising tx_avail.
    logic [7:0] tx_mem [0:255];
    int         tx_ptr = 0;
    int         tx_avail = 0;
    assign tx_empty = (tx_ptr >= tx_avail);

    always @(posedge clk) begin
        if (tx_rd) begin
            tx_rdata <= tx_mem[tx_ptr & 255];
            tx_ptr   <= tx_ptr + 1;
        end
    end

    // SPI slave model: miso bit k is presented until the k-th sclk rise.
    logic miso_bits [0:4095];
    logic mosi_log  [0:4095];
    int   rise_cnt = 0;
    assign miso = miso_bits[rise_cnt & 4095];

    always @(posedge sclk) begin
        mosi_log[rise_cnt & 4095] <= mosi;
        rise_cnt                  <= rise_cnt + 1;
    end

    // RX FIFO and strobe monitors.
    logic [7:0] rx_log [0:255];
    int         rx_cnt = 0;
    int         tx_rd_cnt = 0;
    int         both_cnt = 0;

    always @(posedge clk) begin
        if (rx_wr) begin
            rx_log[rx_cnt & 255] <= rx_wdata;
            rx_cnt               <= rx_cnt + 1;
        end
        if (tx_rd) tx_rd_cnt <= tx_rd_cnt + 1;
        if (tx_rd && rx_wr) both_cnt <= both_cnt + 1;
    end

    int checks = 0;
    int passes = 0;

    // Current transfer description.
    logic [7:0] xb [0:7];
    logic       mb [0:63];
    int         xn;
    int         cur_len;
    logic       cur_op;
    int         rbase;
    int         rd0;
    int         wr0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load(input int n_bits, input logic o, input int ntx);
        cur_len  = n_bits;
        cur_op   = o;
        xn       = ntx;
        tx_avail = tx_ptr;
        for (int k = 0; k < ntx; k++) tx_mem[(tx_avail + k) & 255] = xb[k];
        tx_avail = tx_avail + ntx;
        rbase    = rise_cnt;
        for (int i = 0; i < n_bits; i++) miso_bits[(rbase + i) & 4095] = mb[i];
        rd0 = tx_rd_cnt;
        wr0 = rx_cnt;
    endtask

    task automatic randomize_data();
        for (int k = 0; k < 8; k++) xb[k] = 8'($urandom);
        for (int i = 0; i < 64; i++) mb[i] = 1'($urandom);
    endtask

    task automatic start(input string tag);
        @(negedge clk);
        len  = cur_len[15:0];
        op   = cur_op;
        work = 1'b1;
        @(negedge clk);
        work = 1'b0;
        check({tag, " start busy/cs_n"}, {30'd0, busy, cs_n}, 32'b10);
    endtask

    task automatic finish(input string tag);
        int k;
        int ng;
        int nb;
        int g_exp;
        int g_obs;
        k = 0;
        while (!cs_n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check({tag, " cs_n rise in time"}, (k < 5000), 1);
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, " cs_n hold cycles"}, k, CLK_DIV);

        ng = (cur_len + 7) / 8;
        check({tag, " sclk rises"}, rise_cnt - rbase, cur_len);
        for (int g = 0; g < ng; g++) begin
            nb    = (cur_len - 8 * g < 8) ? cur_len - 8 * g : 8;
            g_exp = ((g < xn) ? int'(xb[g]) : 0) >> (8 - nb);
            g_obs = 0;
            for (int j = 0; j < nb; j++) g_obs = (g_obs << 1) | int'(mosi_log[(rbase + 8 * g + j) & 4095]);
            check($sformatf("%s mosi group %0d", tag, g), g_obs, g_exp);
        end
        check({tag, " tx_rd count"}, tx_rd_cnt - rd0, (ng < xn) ? ng : xn);
        check({tag, " rx_wr count"}, rx_cnt - wr0, cur_op ? 0 : ng);
        if (!cur_op) begin
            for (int g = 0; g < ng; g++) begin
                nb    = (cur_len - 8 * g < 8) ? cur_len - 8 * g : 8;
                g_exp = 0;
                for (int j = 0; j < nb; j++) g_exp = (g_exp << 1) | int'(mb[8 * g + j]);
                check($sformatf("%s rx word %0d", tag, g), rx_log[(wr0 + g) & 255], g_exp);
            end
        end
    endtask

    initial begin
        int k;
        int viol;
        int r0;
        int w0;
        int t0;

        for (int i = 0; i < 4096; i++) miso_bits[i] = 1'b0;

        // Reset values.
        #12;
        check("reset outputs", {26'd0, busy, cs_n, sclk, mosi, tx_rd, rx_wr}, 32'b010000);
        check("reset rx_wdata", rx_wdata, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 40-bit read, TX holds three bytes, last two received bytes A5, 3C.
        randomize_data();
        xb[0] = 8'hF0; xb[1] = 8'h19; xb[2] = 8'h00;
        for (int j = 0; j < 8; j++) begin
            mb[24 + j] = k[0];
            k          = 32'hA5 >> (7 - j);
            mb[24 + j] = k[0];
            k          = 32'h3C >> (7 - j);
            mb[32 + j] = k[0];
        end
        load(40, 1'b0, 3);
        start("len40");
        finish("len40");

        // 16-bit write.
        randomize_data();
        xb[0] = 8'h9F; xb[1] = 8'h01;
        load(16, 1'b1, 2);
        start("wr16");
        finish("wr16");

        // len=0 request is ignored.
        r0 = tx_rd_cnt; w0 = rx_cnt; t0 = rise_cnt; viol = 0;
        @(negedge clk);
        len = 16'd0; op = 1'b0; work = 1'b1;
        @(negedge clk);
        work = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (busy || !cs_n || sclk) viol++;
            @(negedge clk);
        end
        check("len0 pins idle", viol, 0);
        check("len0 no strobes", (tx_rd_cnt - r0) + (rx_cnt - w0) + (rise_cnt - t0), 0);

        // 12-bit read, all ones, TX non-empty for both groups.
        randomize_data();
        for (int i = 0; i < 12; i++) mb[i] = 1'b1;
        load(12, 1'b0, 2);
        start("len12a");
        finish("len12a");
        // Same, but TX runs dry for the partial group.
        randomize_data();
        for (int i = 0; i < 12; i++) mb[i] = 1'b1;
        load(12, 1'b0, 1);
        start("len12b");
        finish("len12b");

        // RX FIFO full stall before the second push.
        randomize_data();
        load(24, 1'b0, 3);
        start("stall");
        k = 0;
        while (rx_cnt == wr0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        rx_full = 1'b1;
        while (rise_cnt - rbase < 16 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        while (sclk && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("stall reached", (k < 2000), 1);
        t0 = rise_cnt; w0 = rx_cnt; viol = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sclk || cs_n || !busy) viol++;
        end
        check("stall pins held", viol, 0);
        check("stall no activity", (rise_cnt - t0) + (rx_cnt - w0), 0);
        rx_full = 1'b0;
        finish("stall");

        // Reset during byte 2, then a clean transfer with an ignored mid-transfer request.
        randomize_data();
        load(24, 1'b0, 3);
        start("rst");
        k = 0;
        while (rise_cnt - rbase < 13 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("rst reached bit", (k < 2000), 1);
        #1 rst = 1'b0;
        #1;
        check("rst async outputs", {26'd0, busy, cs_n, sclk, mosi, tx_rd, rx_wr}, 32'b010000);
        check("rst rx_wdata", rx_wdata, 0);
        r0 = tx_rd_cnt; w0 = rx_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("rst no strobes", (tx_rd_cnt - r0) + (rx_cnt - w0), 0);
        check("rst idle after", {30'd0, busy, cs_n}, 32'b01);

        randomize_data();
        load(32, 1'b0, 4);
        start("post_rst");
        repeat (20) @(negedge clk);
        len = 16'd8; op = 1'b1; work = 1'b1;
        @(negedge clk);
        work = 1'b0;
        finish("post_rst");
        repeat (4) @(negedge clk);
        check("busy work ignored", busy, 0);

        // Randomized transfers.
        for (int t = 0; t < 5; t++) begin
            randomize_data();
            load($urandom_range(1, 40), 1'($urandom), $urandom_range(0, 5));
            start($sformatf("rnd%0d", t));
            finish($sformatf("rnd%0d", t));
        end

        check("tx_rd and rx_wr never together", both_cnt, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
